// File: rtl/graph_pkg.sv
// Shared types and defaults for the graph fetch/writeback blocks.
// The writer state enum is also used by benches to decode the FSM state.
package graph_pkg;

   localparam int GRAPH_ADDR_W     = 32;
   localparam int GRAPH_DATA_W     = 32;
   localparam int GRAPH_DIM        = 4;
   localparam int GRAPH_FIFO_DEPTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } wr_state_t;

endpackage

// File: rtl/graph_pos_writer_if.sv
// Request, position-stream and memory write-port signals of graph_pos_writer.
// The slave modport is the writer; the master modport is the surrounding datapath and memory.
interface graph_pos_writer_if
   import graph_pkg::*;
#(
   parameter int ADDR_W = GRAPH_ADDR_W,
   parameter int DATA_W = GRAPH_DATA_W
) ();

   logic [ADDR_W-1:0] v_addr_in;
   logic              valid_in;
   logic              ready_out;
   logic [DATA_W-1:0] pos_data_in;
   logic              pos_valid_in;
   logic              pos_ready_out;
   logic              mem_wr_out;
   logic [ADDR_W-1:0] mem_addr_out;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_ready_in;
   logic              done_out;
   logic              busy_out;
   logic              fifo_full_out;
   logic              fifo_empty_out;

   modport slave (
      input  v_addr_in, valid_in, pos_data_in, pos_valid_in, mem_ready_in,
      output ready_out, pos_ready_out, mem_wr_out, mem_addr_out, mem_data_out,
             done_out, busy_out, fifo_full_out, fifo_empty_out
   );

   modport master (
      output v_addr_in, valid_in, pos_data_in, pos_valid_in, mem_ready_in,
      input  ready_out, pos_ready_out, mem_wr_out, mem_addr_out, mem_data_out,
             done_out, busy_out, fifo_full_out, fifo_empty_out
   );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data always presents the head entry.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              wr_ok;
   logic              rd_ok;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr_q];

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the pointers alone define what is valid.
   always_ff @(posedge clk_in) begin
      if (wr_ok) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/graph_pos_writer.sv
// Commits DIM position words of one vertex to graph memory at base..base+DIM-1,
// buffering the producer through a FIFO so memory stalls never drop or repeat data.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | waiting for a vertex request, position stream closed
//   ST_WRITE | accepting words into the FIFO and issuing memory writes
//   ST_DONE  | last write accepted; done_out pulses for this one cycle
module graph_pos_writer
   import graph_pkg::*;
#(
   parameter int DIM        = GRAPH_DIM,
   parameter int ADDR_W     = GRAPH_ADDR_W,
   parameter int DATA_W     = GRAPH_DATA_W,
   parameter int FIFO_DEPTH = GRAPH_FIFO_DEPTH
) (
   input  logic               clk_in,
   input  logic               rst_in,
   graph_pos_writer_if.slave  bus
);

   localparam int CNT_W = $clog2(DIM + 1);
   localparam logic [CNT_W-1:0] DIM_C    = CNT_W'(DIM);
   localparam logic [CNT_W-1:0] DIM_M1_C = CNT_W'(DIM - 1);

   wr_state_t         state_q;
   wr_state_t         state_d;
   logic [ADDR_W-1:0] base_q;
   logic [CNT_W-1:0]  in_cnt_q;
   logic [CNT_W-1:0]  ld_cnt_q;
   logic [CNT_W-1:0]  wr_cnt_q;
   logic              out_vld_q;
   logic [ADDR_W-1:0] out_addr_q;
   logic [DATA_W-1:0] out_data_q;

   logic              fifo_wr;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;
   logic              start;
   logic              load;
   logic              wr_accept;
   logic              last_accept;

   assign start       = (state_q == ST_IDLE) && bus.valid_in;
   assign wr_accept   = out_vld_q && bus.mem_ready_in;
   assign last_accept = wr_accept && (wr_cnt_q == DIM_M1_C);
   // Output register refills when empty or when its current word leaves this cycle.
   assign load        = (state_q == ST_WRITE) && !fifo_empty && (!out_vld_q || bus.mem_ready_in);

   assign bus.pos_ready_out  = (state_q == ST_WRITE) && !fifo_full && (in_cnt_q != DIM_C);
   assign fifo_wr            = bus.pos_valid_in && bus.pos_ready_out;

   assign bus.ready_out      = (state_q == ST_IDLE);
   assign bus.busy_out       = (state_q != ST_IDLE);
   assign bus.done_out       = (state_q == ST_DONE);
   assign bus.mem_wr_out     = out_vld_q;
   assign bus.mem_addr_out   = out_addr_q;
   assign bus.mem_data_out   = out_data_q;
   assign bus.fifo_full_out  = fifo_full;
   assign bus.fifo_empty_out = fifo_empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_pos_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .wr_en   (fifo_wr),
      .wr_data (bus.pos_data_in),
      .rd_en   (load),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_in) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.valid_in) state_d = ST_WRITE;
         ST_WRITE: if (last_accept)  state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         base_q     <= '0;
         in_cnt_q   <= '0;
         ld_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         out_vld_q  <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
      end else begin
         if (start) begin
            base_q   <= bus.v_addr_in;
            in_cnt_q <= '0;
            ld_cnt_q <= '0;
            wr_cnt_q <= '0;
         end else begin
            if (fifo_wr)   in_cnt_q <= in_cnt_q + 1'b1;
            if (load)      ld_cnt_q <= ld_cnt_q + 1'b1;
            if (wr_accept) wr_cnt_q <= wr_cnt_q + 1'b1;
         end

         // Address follows load order, so it wraps modulo 2^ADDR_W on its own.
         if (load) begin
            out_vld_q  <= 1'b1;
            out_addr_q <= base_q + ADDR_W'(ld_cnt_q);
            out_data_q <= fifo_head;
         end else if (wr_accept) begin
            out_vld_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_graph_pos_writer.sv
// Directed bench for graph_pos_writer with a 2-entry FIFO so stall and full cases are short.
module tb_graph_pos_writer;
   import graph_pkg::*;

   localparam int DIM = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int FD  = 2;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   always #5 clk_in = ~clk_in;

   graph_pos_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   graph_pos_writer #(
      .DIM(DIM), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Monitor: records accepted writes, handshakes, done pulses and hold-rule breaks.
   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];
   int            wc_q[$];
   int            hs_q[$];
   int            cyc      = 0;
   int            done_cnt = 0;
   int            hold_err = 0;
   int            pos_acc  = 0;
   logic          prev_stall = 1'b0;
   logic [AW-1:0] prev_addr  = '0;
   logic [DW-1:0] prev_data  = '0;

   always @(posedge clk_in) cyc++;

   always @(negedge clk_in) begin
      if (rst_in) begin
         if (bus.done_out) done_cnt++;
         if (prev_stall && (!bus.mem_wr_out || bus.mem_addr_out !== prev_addr ||
                            bus.mem_data_out !== prev_data))
            hold_err++;
         if (bus.pos_valid_in && bus.pos_ready_out) begin
            pos_acc++;
            hs_q.push_back(cyc);
         end
         if (bus.mem_wr_out && bus.mem_ready_in) begin
            wa_q.push_back(bus.mem_addr_out);
            wd_q.push_back(bus.mem_data_out);
            wc_q.push_back(cyc);
         end
         prev_stall = bus.mem_wr_out && !bus.mem_ready_in;
         prev_addr  = bus.mem_addr_out;
         prev_data  = bus.mem_data_out;
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Memory-side ready: either a fixed level or the repeating pattern 1,0,0,1,0,1,1,0.
   logic       rdy_level  = 1'b1;
   logic       rdy_toggle = 1'b0;
   logic [7:0] rdy_pat    = 8'b0110_1001;
   int         rdy_idx    = 0;

   always @(posedge clk_in) begin
      #1;
      if (rdy_toggle) begin
         bus.mem_ready_in = rdy_pat[rdy_idx];
         rdy_idx = (rdy_idx + 1) % 8;
      end else begin
         bus.mem_ready_in = rdy_level;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic start_req(input logic [AW-1:0] a);
      bus.v_addr_in = a;
      bus.valid_in  = 1'b1;
      tick(1);
      bus.valid_in  = 1'b0;
   endtask

   // Offers n words d0, d0+1, ...; each word is dropped if not taken within budget cycles.
   task automatic send(input logic [DW-1:0] d0, input int n, input int budget, output int acc);
      acc = 0;
      for (int i = 0; i < n; i++) begin
         bit taken;
         taken = 1'b0;
         bus.pos_data_in  = d0 + DW'(i);
         bus.pos_valid_in = 1'b1;
         for (int b = 0; b < budget && !taken; b++) begin
            @(negedge clk_in);
            taken = bus.pos_ready_out;
            @(posedge clk_in);
            #1;
         end
         if (taken) acc++;
      end
      bus.pos_valid_in = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d_start, input int budget);
      int b;
      b = 0;
      while (done_cnt == d_start && b < budget) begin
         tick(1);
         b++;
      end
      chk(tag, done_cnt != d_start, 1'b1);
   endtask

   task automatic chk_writes(input string tag, input logic [AW-1:0] base,
                             input logic [DW-1:0] d0, input int n, input int w0);
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      chk({tag, "_nwr"}, wa_q.size() - w0, n);
      for (int i = 0; i < n && (w0 + i) < wa_q.size(); i++) begin
         ea = base + AW'(i);
         ed = d0 + DW'(i);
         chk($sformatf("%s_addr%0d", tag, i), wa_q[w0+i], ea);
         chk($sformatf("%s_data%0d", tag, i), wd_q[w0+i], ed);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"},   bus.ready_out,      1'b1);
      chk({tag, "_pready"},  bus.pos_ready_out,  1'b0);
      chk({tag, "_wr"},      bus.mem_wr_out,     1'b0);
      chk({tag, "_addr"},    bus.mem_addr_out,   '0);
      chk({tag, "_data"},    bus.mem_data_out,   '0);
      chk({tag, "_done"},    bus.done_out,       1'b0);
      chk({tag, "_busy"},    bus.busy_out,       1'b0);
      chk({tag, "_empty"},   bus.fifo_empty_out, 1'b1);
      chk({tag, "_full"},    bus.fifo_full_out,  1'b0);
      chk({tag, "_state"},   dut.state_q,        ST_IDLE);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, w0, h0, d0c, p0, he0, b;

      bus.v_addr_in    = '0;
      bus.valid_in     = 1'b0;
      bus.pos_data_in  = '0;
      bus.pos_valid_in = 1'b0;

      rst_in = 1'b0;
      tick(3);
      chk_reset_outputs("rst");
      rst_in = 1'b1;
      tick(2);

      // Words offered while idle must not be taken.
      p0 = pos_acc;
      bus.pos_data_in  = 32'hDEAD;
      bus.pos_valid_in = 1'b1;
      tick(3);
      chk("idle_pready", bus.pos_ready_out, 1'b0);
      bus.pos_valid_in = 1'b0;
      tick(1);
      chk("idle_no_accept", pos_acc - p0, 0);
      chk("idle_empty", bus.fifo_empty_out, 1'b1);

      // Basic: base 1, words A0..A3, memory always ready.
      w0 = wa_q.size(); h0 = hs_q.size(); d0c = done_cnt;
      chk("basic_ready_before", bus.ready_out, 1'b1);
      start_req(32'd1);
      chk("basic_busy", bus.busy_out, 1'b1);
      send(32'hA0, 4, 10, acc);
      chk("basic_acc", acc, 4);
      wait_done("basic_done", d0c, 20);
      tick(3);
      chk("basic_done_once", done_cnt - d0c, 1);
      chk("basic_ready_after", bus.ready_out, 1'b1);
      chk_writes("basic", 32'd1, 32'hA0, 4, w0);
      chk("basic_latency", wc_q[w0] - hs_q[h0], 2);
      chk("basic_back2back", wc_q[w0+3] - wc_q[w0], 3);

      // Backpressure: ready pattern 1,0,0,1,0,1,1,0 while writing to 55..58.
      w0 = wa_q.size(); d0c = done_cnt; he0 = hold_err;
      rdy_toggle = 1'b1;
      start_req(32'd55);
      send(32'hB0, 4, 40, acc);
      wait_done("bp_done", d0c, 60);
      tick(2);
      rdy_toggle = 1'b0;
      tick(2);
      chk("bp_acc", acc, 4);
      chk("bp_done_once", done_cnt - d0c, 1);
      chk("bp_hold", hold_err - he0, 0);
      chk_writes("bp", 32'd55, 32'hB0, 4, w0);

      // FIFO full under a hard stall: the output register takes one word,
      // the 2-entry FIFO two more, so FD+1 words are accepted before pos_ready drops.
      w0 = wa_q.size(); d0c = done_cnt; p0 = pos_acc; he0 = hold_err;
      rdy_level = 1'b0;
      tick(2);
      start_req(32'd64);
      fork
         send(32'hC0, 4, 40, acc);
         begin
            tick(10);
            chk("full_flag", bus.fifo_full_out, 1'b1);
            chk("full_pready", bus.pos_ready_out, 1'b0);
            chk("full_acc", pos_acc - p0, FD + 1);
            chk("full_no_write", wa_q.size() - w0, 0);
            chk("full_wr_held", bus.mem_wr_out, 1'b1);
            chk("full_addr_held", bus.mem_addr_out, 32'd64);
            chk("full_data_held", bus.mem_data_out, 32'hC0);
            rdy_level = 1'b1;
         end
      join
      wait_done("full_done", d0c, 40);
      tick(2);
      chk("full_total_acc", acc, 4);
      chk("full_hold", hold_err - he0, 0);
      chk_writes("full", 32'd64, 32'hC0, 4, w0);

      // Overrun: six words offered, only DIM taken.
      w0 = wa_q.size(); d0c = done_cnt; p0 = pos_acc;
      start_req(32'd200);
      send(32'hD0, 6, 6, acc);
      chk("ovr_acc", acc, 4);
      wait_done("ovr_done", d0c, 20);
      tick(2);
      chk("ovr_pos_acc", pos_acc - p0, 4);
      chk_writes("ovr", 32'd200, 32'hD0, 4, w0);

      // Address wrap past 2^32.
      w0 = wa_q.size(); d0c = done_cnt;
      start_req(32'hFFFF_FFFE);
      send(32'hE0, 4, 10, acc);
      wait_done("wrap_done", d0c, 20);
      tick(2);
      chk_writes("wrap", 32'hFFFF_FFFE, 32'hE0, 4, w0);

      // Reset after two writes aborts the transfer.
      w0 = wa_q.size(); d0c = done_cnt;
      start_req(32'd300);
      fork
         send(32'hF0, 4, 8, acc);
         begin
            b = 0;
            while ((wa_q.size() - w0) < 2 && b < 40) begin
               @(negedge clk_in);
               #1;
               b++;
            end
            rst_in = 1'b0;
         end
      join
      tick(3);
      chk_reset_outputs("midrst");
      rst_in = 1'b1;
      tick(6);
      chk("midrst_writes", wa_q.size() - w0, 2);
      chk("midrst_no_done", done_cnt - d0c, 0);
      chk("midrst_wr_idle", bus.mem_wr_out, 1'b0);

      w0 = wa_q.size(); d0c = done_cnt;
      start_req(32'd1);
      send(32'h10, 4, 10, acc);
      wait_done("postrst_done", d0c, 20);
      tick(2);
      chk_writes("postrst", 32'd1, 32'h10, 4, w0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
